// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - state, opcode and datapath select encodings for the RV32I multicycle control unit
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // alu_op values are decoded by alu_control
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

  // States that sit on the memory handshake
  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/stall_timer.sv
// rtl/stall_timer.sv - memory-wait watchdog; counts held wait-state cycles and flags a timeout at STALL_LIMIT
module stall_timer #(
  parameter int unsigned STALL_LIMIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  logic [15:0] count;
  logic [16:0] count_inc;
  logic        stalled;

  assign stalled   = waiting && !mem_ready;
  assign count_inc = {1'b0, count} + 17'd1;

  // Any cycle that is not a held stall clears the count, so every entry into a wait state starts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (stalled) begin
      count <= count_inc[15:0];
    end else begin
      count <= '0;
    end
  end

  // mem_ready in the limit cycle keeps stalled low, so a completing access always wins
  assign timeout = (STALL_LIMIT != 0) && stalled && (count_inc == 17'(STALL_LIMIT));

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle RV32I main control FSM; FSM_PERF_CNT_EN adds retired/stall counters
module main_control_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       illegal_instr,
  output logic       mem_timeout,
  output logic [3:0] state_dbg
`ifdef FSM_PERF_CNT_EN
  ,
  output logic [31:0] instr_retired,
  output logic [31:0] stall_cycles
`endif
);

  state_t state;
  state_t state_next;
  logic   trap_from_timeout;
  logic   waiting;
  logic   timeout;

  assign waiting = is_wait_state(state);

  stall_timer #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall_timer (
    .clk      (clk),
    .rst      (rst),
    .waiting  (waiting),
    .mem_ready(mem_ready),
    .timeout  (timeout)
  );

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:    state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECUTER;
          OP_ITYPE:          state_next = S_EXECUTEI;
          OP_BRANCH:         state_next = S_BRANCH;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      default:    state_next = S_FETCH;
    endcase
    if (timeout) begin
      state_next = S_TRAP;
    end
  end

  // trap_from_timeout suppresses illegal_instr for a watchdog-induced TRAP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_FETCH;
      trap_from_timeout <= 1'b0;
    end else begin
      state             <= state_next;
      trap_from_timeout <= timeout;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    adr_src       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    result_src    = RES_ALUOUT;
    alu_op        = ALU_ADD;
    illegal_instr = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_SUB;
        pc_write  = zero;
      end
      S_TRAP: begin
        illegal_instr = !trap_from_timeout;
      end
      default: begin
      end
    endcase
  end

  assign mem_timeout = timeout;
  assign state_dbg   = state;

`ifdef FSM_PERF_CNT_EN
  logic retire;

  always_comb begin
    retire = 1'b0;
    if (state_next == S_FETCH) begin
      retire = (state == S_MEMWB) || (state == S_MEMWRITE) ||
               (state == S_ALUWB) || (state == S_BRANCH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_retired <= '0;
      stall_cycles  <= '0;
    end else begin
      if (retire) begin
        instr_retired <= instr_retired + 32'd1;
      end
      if (waiting && !mem_ready) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
